// File: rtl/float_unpack_pipe.sv
// Two-stage float unpacker: split fields, classify, extend mantissa.
// Define FLOAT_UNPACK_NORM_EN to normalise subnormals; class port is fp_type (type is reserved).
module float_unpack_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int SW = $clog2(MAN_W + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] number,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp,
  output logic [MAN_W-1:0]     mantis,
  output logic [MAN_W+2:0]     ext_mantis,
  output logic [2:0]           fp_type,
  output logic [SW-1:0]        norm_shift
);

  logic             s1_valid;
  logic             s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W-1:0] s1_man;
  logic             s2_adv;

  logic             exp_zero;
  logic             exp_ones;
  logic             man_zero;
  logic             man_msb;
  logic             hidden;
  logic [2:0]       cls;
  logic [MAN_W:0]   sig;
  logic [MAN_W:0]   sig_n;
  logic [SW-1:0]    lz;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_adv);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_man   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        {s1_sign, s1_exp, s1_man} <= number;
      end
    end
  end

  always_comb begin
    exp_zero = (s1_exp == '0);
    exp_ones = &s1_exp;
    man_zero = (s1_man == '0);
    man_msb  = s1_man[MAN_W-1];
    hidden   = !exp_zero;
    cls      = 3'd2;
    unique case (1'b1)
      exp_zero && man_zero:              cls = 3'd0;
      exp_zero && !man_zero:             cls = 3'd1;
      exp_ones && man_zero:              cls = 3'd3;
      exp_ones && man_msb:               cls = 3'd4;
      exp_ones && !man_msb && !man_zero: cls = 3'd5;
      default:                           cls = 3'd2;
    endcase
  end

  always_comb begin
    sig = {hidden, s1_man};
    lz  = '0;
`ifdef FLOAT_UNPACK_NORM_EN
    // Highest set bit wins, so scan upward and keep the last hit.
    if (cls == 3'd1) begin
      for (int i = 0; i <= MAN_W; i++) begin
        if (sig[i]) lz = SW'(MAN_W - i);
      end
    end
`endif
    sig_n = sig << lz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      sign       <= 1'b0;
      exp        <= '0;
      mantis     <= '0;
      ext_mantis <= '0;
      fp_type    <= '0;
      norm_shift <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sign       <= s1_sign;
        exp        <= s1_exp;
        mantis     <= s1_man;
        ext_mantis <= {1'b0, sig_n, 1'b0};
        fp_type    <= cls;
        norm_shift <= lz;
      end
    end
  end

endmodule

// File: tb/tb_float_unpack_pipe.sv
// Scoreboard bench for float_unpack_pipe: directed vectors,
// stalls, mid-flight reset and a half-precision instance.
module tb_float_unpack_pipe;

`ifdef FLOAT_UNPACK_NORM_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] number;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [7:0]  exp;
  logic [22:0] mantis;
  logic [25:0] ext_mantis;
  logic [2:0]  fp_type;
  logic [4:0]  norm_shift;

  logic        h_in_valid;
  logic        h_in_ready;
  logic [15:0] h_number;
  logic        h_out_valid;
  logic        h_out_ready;
  logic        h_sign;
  logic [4:0]  h_exp;
  logic [9:0]  h_mantis;
  logic [12:0] h_ext;
  logic [2:0]  h_type;
  logic [3:0]  h_ns;

  float_unpack_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .number     (number),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign       (sign),
    .exp        (exp),
    .mantis     (mantis),
    .ext_mantis (ext_mantis),
    .fp_type    (fp_type),
    .norm_shift (norm_shift)
  );

  float_unpack_pipe #(.EXP_W(5), .MAN_W(10)) dut_half (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (h_in_valid),
    .in_ready   (h_in_ready),
    .number     (h_number),
    .out_valid  (h_out_valid),
    .out_ready  (h_out_ready),
    .sign       (h_sign),
    .exp        (h_exp),
    .mantis     (h_mantis),
    .ext_mantis (h_ext),
    .fp_type    (h_type),
    .norm_shift (h_ns)
  );

  logic [31:0] v_num [10] = '{
    32'h3F800000, 32'h80000000, 32'h7F800000, 32'h7FC00000, 32'h7F800001,
    32'h00000001, 32'hC0490FDB, 32'h00400000, 32'h007FFFFF, 32'hFFA00000};
  logic [2:0]  v_t   [10] = '{3'd2, 3'd0, 3'd3, 3'd4, 3'd5,
                              3'd1, 3'd2, 3'd1, 3'd1, 3'd5};
  logic [25:0] v_x   [10] = '{
    26'h1000000, 26'h0000000, 26'h1000000, 26'h1800000, 26'h1000002,
    26'h0000002, 26'h1921FB6, 26'h0800000, 26'h0FFFFFE, 26'h1400000};
  logic [25:0] v_xn  [10] = '{
    26'h1000000, 26'h0000000, 26'h1000000, 26'h1800000, 26'h1000002,
    26'h1000000, 26'h1921FB6, 26'h1000000, 26'h1FFFFFC, 26'h1400000};
  logic [4:0]  v_nsn [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                              5'd23, 5'd0, 5'd1, 5'd1, 5'd0};

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [25:0] x;
    logic [2:0]  t;
    logic [4:0]  ns;
    logic [31:0] cyc;
    logic        lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        p;
  exp_t        q;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          to_cnt = 0;
  int          to_seen = 0;
  logic        have = 1'b0;
  logic [65:0] held;

  logic [2:0]  cur_t;
  logic [25:0] cur_x;
  logic [4:0]  cur_ns;
  logic        cur_lat;
  logic        probe_rst = 1'b0;
  logic        probe_idle = 1'b0;
  logic        probe_full = 1'b0;
  logic        probe_half = 1'b0;
  logic        probe_end = 1'b0;

  wire [65:0] bundle = {sign, exp, mantis, ext_mantis, fp_type, norm_shift};

  task automatic cmp(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      have = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          cmp("unexpected_out", {sign, exp, mantis}, 0);
        end else begin
          p = sb.pop_front();
          cmp("sign", sign, p.s);
          cmp("exp", exp, p.e);
          cmp("mantis", mantis, p.m);
          cmp("ext_mantis", ext_mantis, p.x);
          cmp("type", fp_type, p.t);
          cmp("norm_shift", norm_shift, p.ns);
          if (p.lat) cmp("latency", cyc - p.cyc, 2);
        end
      end
      if (have) begin
        cmp("hold_valid", out_valid, 1);
        cmp("hold_data", bundle, held);
      end
      if (out_valid && !out_ready) begin
        held = bundle;
        have = 1'b1;
      end else begin
        have = 1'b0;
      end
      if (in_valid && in_ready) begin
        q.s   = number[31];
        q.e   = number[30:23];
        q.m   = number[22:0];
        q.x   = cur_x;
        q.t   = cur_t;
        q.ns  = cur_ns;
        q.cyc = cyc;
        q.lat = cur_lat;
        sb.push_back(q);
      end
    end
    if (to_cnt != to_seen) begin
      cmp("timeout", to_cnt - to_seen, 0);
      to_seen = to_cnt;
    end
    if (probe_rst) begin
      cmp("rst_in_ready", in_ready, 0);
      cmp("rst_h_in_ready", h_in_ready, 0);
    end
    if (probe_idle) begin
      cmp("idle_valid", out_valid, 0);
      cmp("idle_fields", bundle, 0);
    end
    if (probe_full) begin
      cmp("full_in_ready", in_ready, 0);
      cmp("full_out_valid", out_valid, 1);
    end
    if (probe_half) begin
      cmp("h_valid", h_out_valid, 1);
      cmp("h_sign", h_sign, 0);
      cmp("h_exp", h_exp, 5'h0F);
      cmp("h_mantis", h_mantis, 0);
      cmp("h_type", h_type, 2);
      cmp("h_ext", h_ext, 13'h0800);
      cmp("h_ns", h_ns, 0);
    end
    if (probe_end) cmp("sb_empty", sb.size(), 0);
  end

  task automatic send(input int i, input logic lat);
    int k;
    number  = v_num[i];
    cur_t   = v_t[i];
    cur_x   = NORM ? v_xn[i] : v_x[i];
    cur_ns  = NORM ? v_nsn[i] : 5'd0;
    cur_lat = lat;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) to_cnt++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) to_cnt++;
    @(posedge clk);
    #1;
  endtask

  logic [11:0] pat = 12'b1011_0010_0110;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    number = '0;
    out_ready = 1'b1;
    h_in_valid = 1'b0;
    h_number = '0;
    h_out_ready = 1'b1;
    cur_t = '0;
    cur_x = '0;
    cur_ns = '0;
    cur_lat = 1'b0;
    repeat (3) @(posedge clk);
    #1 probe_rst = 1'b1;
    probe_idle = 1'b1;
    @(posedge clk);
    #1 probe_rst = 1'b0;
    probe_idle = 1'b0;
    rst = 1'b0;

    h_number = 16'h3C00;
    h_in_valid = 1'b1;
    @(posedge clk);
    #1 h_in_valid = 1'b0;
    @(posedge clk);
    #1 probe_half = 1'b1;
    @(posedge clk);
    #1 probe_half = 1'b0;

    for (int i = 0; i < 10; i++) send(i, 1'b1);
    drain();

    out_ready = 1'b0;
    send(6, 1'b0);
    send(3, 1'b0);
    probe_full = 1'b1;
    @(posedge clk);
    #1 probe_full = 1'b0;
    fork
      send(8, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    fork
      for (int i = 4; i < 10; i++) send(i, 1'b0);
      begin
        for (int k = 0; k < 12; k++) begin
          out_ready = pat[k];
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    send(2, 1'b0);
    send(5, 1'b0);
    rst = 1'b1;
    probe_rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    probe_rst = 1'b0;
    probe_idle = 1'b1;
    @(posedge clk);
    #1 probe_idle = 1'b0;
    out_ready = 1'b1;
    send(0, 1'b1);
    drain();

    probe_end = 1'b1;
    @(posedge clk);
    #1 probe_end = 1'b0;
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
